// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the pc, issues one memory request at a time,
// and uses a one-entry skid buffer so a word that arrives during a decode stall is not lost.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        FETCH    = 1'b0,
        BUFFERED = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid;
    logic        load;
    logic [31:0] pc_plus4;
    logic [31:0] pc_minus4;

    // An empty IF/ID register can always take an instruction, even under stall.
    assign load      = !stall || !if_id_valid;
    assign pc_plus4  = pc + 32'd4;
    assign pc_minus4 = pc - 32'd4;

    // Gating with rst keeps the request low the instant reset rises, not just after the next edge.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            skid        <= 32'h0000_0000;
            if_id_inst  <= NOP;
            if_id_pc    <= 32'h0000_0000;
            if_id_pc4   <= 32'h0000_0000;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            state       <= FETCH;
            pc          <= {redirect_pc[31:2], 2'b00};
            skid        <= 32'h0000_0000;
            if_id_inst  <= NOP;
            if_id_pc    <= 32'h0000_0000;
            if_id_pc4   <= 32'h0000_0000;
            if_id_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc <= pc_plus4;
                        if (load) begin
                            if_id_inst  <= imem_rdata;
                            if_id_pc    <= pc;
                            if_id_pc4   <= pc_plus4;
                            if_id_valid <= 1'b1;
                        end else begin
                            skid  <= imem_rdata;
                            state <= BUFFERED;
                        end
                    end else if (load) begin
                        if_id_valid <= 1'b0;
                    end
                end
                // pc already points past the buffered word, so its address is pc-4.
                BUFFERED: begin
                    if (!stall) begin
                        if_id_inst  <= skid;
                        if_id_pc    <= pc_minus4;
                        if_id_pc4   <= pc;
                        if_id_valid <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a queue of owed instructions in program order
// predicts every request, every issued instruction and every redirect flush.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    logic        w_rst;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic        w_valid;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] fetch_addr;
    logic        prev_redirect;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = imem_ready ? word_at(imem_addr) : 32'hDEAD_BEEF;
    assign w_rdata    = word_at(w_addr);

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_inst(if_id_inst), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(w_rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0000_0000),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(w_rdata),
        .if_id_inst(w_inst), .if_id_pc(w_pc), .if_id_pc4(w_pc4), .if_id_valid(w_valid)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        imem_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    // Monitor: on the falling edge the outputs reflect the last edge and the inputs for the
    // next edge are stable, so check the present state and then advance the model.
    always @(negedge clk) begin
        item_t it;
        int    owed;
        if (rst) begin
            exp_q.delete();
            fetch_addr    = 32'h0000_0000;
            prev_redirect = 1'b0;
        end else begin
            owed = exp_q.size();
            checkOutput("imem_req", 32'(imem_req), 32'(owed < 2));
            checkOutput("if_id_valid", 32'(if_id_valid), 32'(owed > 0));
            checkOutput("imem_addr", imem_addr, fetch_addr);
            if (prev_redirect) begin
                checkOutput("flush_inst", if_id_inst, NOP);
                checkOutput("flush_pc", if_id_pc, 32'h0000_0000);
                checkOutput("flush_pc4", if_id_pc4, 32'h0000_0000);
            end
            if (redirect) begin
                exp_q.delete();
                fetch_addr    = {redirect_pc[31:2], 2'b00};
                prev_redirect = 1'b1;
            end else begin
                prev_redirect = 1'b0;
                if (owed > 0 && !stall) begin
                    it = exp_q.pop_front();
                    checkOutput("issue_pc", if_id_pc, it.pc);
                    checkOutput("issue_inst", if_id_inst, it.inst);
                    checkOutput("issue_pc4", if_id_pc4, it.pc + 32'd4);
                end
                if (owed < 2 && imem_ready) begin
                    exp_q.push_back('{fetch_addr, word_at(fetch_addr)});
                    fetch_addr = fetch_addr + 32'd4;
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        w_rst       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        imem_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_inst", if_id_inst, NOP);
        checkOutput("reset_pc", if_id_pc, 32'h0000_0000);
        checkOutput("reset_pc4", if_id_pc4, 32'h0000_0000);
        checkOutput("reset_valid", 32'(if_id_valid), 32'h0);
        checkOutput("reset_req", 32'(imem_req), 32'h0);
        checkOutput("reset_addr", imem_addr, 32'h0000_0000);
        rst = 1'b0;

        // Streaming, then a three-cycle stall that forces the skid buffer to fill.
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h0000_0102, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Two wait states per fetch.
        repeat (4) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        end

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 5),
                          $urandom, 1'($urandom_range(0, 99) < 70));
        end

        // Asynchronous reset in the middle of a stall with a valid instruction held.
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("async_valid", 32'(if_id_valid), 32'h0);
        checkOutput("async_req", 32'(imem_req), 32'h0);
        checkOutput("async_addr", imem_addr, 32'h0000_0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Wrap-around with the high reset address.
        @(posedge clk);
        #1;
        w_rst = 1'b0;
        @(negedge clk);
        checkOutput("wrap_req", 32'(w_req), 32'h1);
        checkOutput("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        checkOutput("wrap_valid", 32'(w_valid), 32'h1);
        checkOutput("wrap_pc", w_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_pc4", w_pc4, 32'h0000_0000);
        checkOutput("wrap_inst", w_inst, word_at(32'hFFFF_FFFC));
        checkOutput("wrap_addr1", w_addr, 32'h0000_0000);
        @(negedge clk);
        checkOutput("wrap_pc_next", w_pc, 32'h0000_0000);
        checkOutput("wrap_pc4_next", w_pc4, 32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The parameter list SHALL be: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 The port clk SHALL be an input, 1 bit, the single clock; all state updates SHALL occur on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit; reset SHALL be asynchronous and active-high.
REQ-004 The port stall SHALL be an input, 1 bit; when high, the decode stage cannot accept a new instruction.
REQ-005 The port redirect SHALL be an input, 1 bit; when high, the front end is flushed and fetch restarts at redirect_pc.
REQ-006 The port redirect_pc SHALL be an input, 32 bits, carrying the target of a taken branch or jump.
REQ-007 The port imem_req SHALL be an output, 1 bit, the instruction-memory request.
REQ-008 The port imem_addr SHALL be an output, 32 bits, the fetch address, equal to pc.
REQ-009 The port imem_ready SHALL be an input, 1 bit; when high, imem_rdata is valid for imem_addr in the same cycle.
REQ-010 The port imem_rdata SHALL be an input, 32 bits, the fetched instruction word.
REQ-011 The port if_id_inst SHALL be an output, 32 bits, the instruction presented to decode and immediate generation.
REQ-012 The port if_id_pc SHALL be an output, 32 bits, the address of if_id_inst.
REQ-013 The port if_id_pc4 SHALL be an output, 32 bits, equal to if_id_pc + 4 (the JAL/JALR link value).
REQ-014 The port if_id_valid SHALL be an output, 1 bit; when high, the if_id_* outputs hold a real instruction.

Function
REQ-015 The block SHALL hold a 32-bit pc register, a 2-state FSM {FETCH, BUFFERED}, a 32-bit one-entry skid buffer, and the IF/ID output registers.
REQ-016 imem_req SHALL be 1 exactly when state is FETCH and rst is low; imem_addr SHALL always equal pc.
REQ-017 Memory contract: while imem_req is high and imem_ready is low, the request is pending. A change of imem_addr or a deassertion of imem_req SHALL abort the pending request with no response owed.
REQ-018 Define the IF/ID load condition as LOAD = !stall || !if_id_valid; an empty IF/ID SHALL always accept an instruction.
REQ-019 In FETCH, with imem_ready=1, LOAD=1 and redirect=0, the block SHALL do all of the following on the next edge:
  - set if_id_inst to imem_rdata;
  - set if_id_pc to pc;
  - set if_id_pc4 to pc+4;
  - set if_id_valid to 1;
  - set pc to pc+4.
  Latency from a hit to a valid output SHALL be 1 cycle, and throughput SHALL be 1 instruction per cycle with zero-wait memory.
REQ-020 In FETCH, with imem_ready=1, LOAD=0 and redirect=0, the block SHALL capture imem_rdata into the skid buffer, set pc to pc+4, go to BUFFERED, and leave the IF/ID registers unchanged.
REQ-021 In FETCH, with imem_ready=1, LOAD=0 and redirect=0, the block SHALL keep the buffered instruction's address as pc-4 when it is next used.
REQ-022 In FETCH, with imem_ready=0 and LOAD=1, the block SHALL clear if_id_valid to 0 (a bubble); with LOAD=0, IF/ID SHALL hold.
REQ-023 In BUFFERED, while stall=1, all state SHALL hold and imem_req SHALL stay 0.
REQ-024 In BUFFERED, when stall=0, IF/ID SHALL load the buffer contents: inst = buffer, pc = pc-4, pc4 = pc, valid = 1. The state SHALL return to FETCH, and pc SHALL be unchanged.
REQ-025 When redirect=1 in any state, it SHALL have priority over stall and imem_ready, and on the next edge the block SHALL:
  - set pc to {redirect_pc[31:2], 2'b00};
  - clear if_id_valid to 0;
  - discard the skid buffer;
  - set the state to FETCH;
  - ignore any imem_rdata in that cycle.
REQ-026 When redirect=1 and if_id_valid=0, if_id_inst, if_id_pc and if_id_pc4 SHALL be don't-care, but they SHALL be set to 32'h0000_0013 (NOP), 0 and 0 respectively.
REQ-027 PC arithmetic SHALL be modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000, and the matching if_id_pc4 SHALL be 0.
REQ-028 The block SHALL never own more than one instruction in flight, whether pending in memory or held in the skid buffer.

Reset
REQ-029 While rst=1, the block SHALL hold: pc=RESET_PC, state=FETCH, buffer=0, if_id_inst=32'h0000_0013, if_id_pc=0, if_id_pc4=0, if_id_valid=0, imem_req=0.
REQ-030 An assertion of rst in the middle of an operation SHALL drop any pending request or buffered instruction immediately, without waiting for a clock edge.
REQ-031 On the first rising edge after rst deasserts, the block SHALL be in a cycle with imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-032 Streaming: zero-wait memory returns word = address, stall=0, redirect=0 -> if_id_pc follows 0, 4, 8, 12 on consecutive cycles, if_id_inst equals if_id_pc, and if_id_pc4 equals if_id_pc+4.
REQ-033 Stall with skid: stall held high for 3 cycles while if_id_pc=8 -> IF/ID holds 8 and the buffer takes 12; one cycle after stall falls, if_id_pc=12; the next fetch address is 16, with no duplicated or lost instruction.
REQ-034 Redirect: redirect=1 with redirect_pc=32'h0000_0102 during a stall while a word is buffered -> next cycle if_id_valid=0, imem_addr=32'h0000_0100, the buffered word is never issued, and the word at 0x100 is issued next.
REQ-035 Wait states: imem_ready low for 2 cycles per fetch -> if_id_valid is 0 in those cycles and pc advances only on cycles where imem_ready=1.
REQ-036 Wrap and reset: with RESET_PC=32'hFFFF_FFFC, one fetch gives if_id_pc=32'hFFFF_FFFC, if_id_pc4=0 and next imem_addr=0; asserting rst asynchronously mid-stall clears if_id_valid and imem_req before the next edge.
